// File: rtl/mr_issue_ctl_pkg.sv
// Shared types and sizing for the issue controller and its scoreboard.
package mr_issue_ctl_pkg;

  localparam int DEF_NREGS     = 32;  // architectural registers, x0 never tracked
  localparam int DEF_REGSEL    = 5;   // register-select width
  localparam int DEF_PEND_BITS = 2;   // pending-write counter width (max 3 outstanding)

  // RUN: normal issue; BR_WAIT: branch in the ALU; FLUSH: one-cycle wrong-path discard.
  typedef enum logic [1:0] {
    IS_RUN,
    IS_BR_WAIT,
    IS_FLUSH
  } e_issue_state;

endpackage

// File: rtl/mr_scoreboard.sv
// Per-register pending-write counters with three lookup ports.
// Lookup A/B report "write pending", lookup C reports "counter saturated".
module mr_scoreboard
  import mr_issue_ctl_pkg::*;
#(
  parameter int NREGS     = DEF_NREGS,
  parameter int REGSEL    = DEF_REGSEL,
  parameter int PEND_BITS = DEF_PEND_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en,
  input  logic [REGSEL-1:0] inc_reg,
  input  logic              dec_en,
  input  logic [REGSEL-1:0] dec_reg,
  input  logic [REGSEL-1:0] look_a,
  input  logic [REGSEL-1:0] look_b,
  input  logic [REGSEL-1:0] look_c,
  output logic              busy_a,
  output logic              busy_b,
  output logic              full_c,
  output logic              any_busy
);

  localparam logic [PEND_BITS-1:0] CNT_MAX = '1;

  logic [PEND_BITS-1:0] cnt_reg  [NREGS];
  logic [PEND_BITS-1:0] cnt_next [NREGS];
  logic [NREGS-1:0]     nonzero;
  logic                 dec_err;

  // Per-register next count: an increment and decrement in the same cycle cancel;
  // a decrement of an empty counter is dropped so the count never wraps.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
    if (gi == 0) begin : g_x0
      assign cnt_next[gi] = '0;
    end else begin : g_trk
      logic inc_hit;
      logic dec_hit;
      assign inc_hit = inc_en && (inc_reg == REGSEL'(gi));
      assign dec_hit = dec_en && (dec_reg == REGSEL'(gi)) && (cnt_reg[gi] != '0);
      assign cnt_next[gi] = (inc_hit && !dec_hit) ? cnt_reg[gi] + 1'b1 :
                            (dec_hit && !inc_hit) ? cnt_reg[gi] - 1'b1 :
                                                    cnt_reg[gi];
    end
    assign nonzero[gi] = (cnt_reg[gi] != '0);
  end

  // Counter storage, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) cnt_reg[i] <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign busy_a   = (cnt_reg[look_a] != '0);
  assign busy_b   = (cnt_reg[look_b] != '0);
  assign full_c   = (cnt_reg[look_c] == CNT_MAX);
  assign any_busy = |nonzero;
  assign dec_err  = dec_en && (cnt_reg[dec_reg] == '0);

  // Retiring a write that was never issued is a protocol error upstream.
  a_no_dec_of_zero: assert property (@(posedge clk) disable iff (rst) !dec_err);

endmodule

// File: rtl/mr_issue_ctl.sv
// Issue controller between ID and the ALU: RAW/WAW hazard stall, branch
// serialisation and a one-cycle flush after a taken branch.
module mr_issue_ctl
  import mr_issue_ctl_pkg::*;
#(
  parameter int NREGS     = DEF_NREGS,
  parameter int REGSEL    = DEF_REGSEL,
  parameter int PEND_BITS = DEF_PEND_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [REGSEL-1:0] dec_rs1,
  input  logic              dec_rs1_used,
  input  logic [REGSEL-1:0] dec_rs2,
  input  logic              dec_rs2_used,
  input  logic [REGSEL-1:0] dec_rd,
  input  logic              dec_is_br,
  output logic              alu_valid,
  input  logic              alu_ready,
  input  logic              br_done,
  input  logic              br_taken,
  input  logic              wb_valid,
  input  logic [REGSEL-1:0] wb_reg,
  output logic              flush,
  output logic              busy
);

  e_issue_state state_reg, state_next;
  logic rs1_busy, rs2_busy, rd_full, sb_busy;
  logic hazard, issue;

  mr_scoreboard #(
    .NREGS    (NREGS),
    .REGSEL   (REGSEL),
    .PEND_BITS(PEND_BITS)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (issue && (dec_rd != '0)),
    .inc_reg (dec_rd),
    .dec_en  (wb_valid && (wb_reg != '0)),
    .dec_reg (wb_reg),
    .look_a  (dec_rs1),
    .look_b  (dec_rs2),
    .look_c  (dec_rd),
    .busy_a  (rs1_busy),
    .busy_b  (rs2_busy),
    .full_c  (rd_full),
    .any_busy(sb_busy)
  );

  // RAW on any used nonzero source; WAW only once the destination counter is saturated.
  assign hazard = (dec_rs1_used && (dec_rs1 != '0) && rs1_busy) ||
                  (dec_rs2_used && (dec_rs2 != '0) && rs2_busy) ||
                  ((dec_rd != '0) && rd_full);

  // Next state and handshake outputs; only RUN passes instructions through.
  always_comb begin
    state_next = state_reg;
    alu_valid  = 1'b0;
    dec_ready  = 1'b0;
    flush      = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      IS_RUN: begin
        alu_valid = dec_valid && !hazard;
        issue     = alu_valid && alu_ready;
        dec_ready = issue;
        if (issue && dec_is_br) state_next = IS_BR_WAIT;
      end
      IS_BR_WAIT: begin
        if (br_done) state_next = br_taken ? IS_FLUSH : IS_RUN;
      end
      IS_FLUSH: begin
        flush      = 1'b1;
        dec_ready  = 1'b1;
        state_next = IS_RUN;
      end
      default: state_next = IS_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IS_RUN;
    else     state_reg <= state_next;
  end

  assign busy = sb_busy || (state_reg != IS_RUN);

  // The ALU reports branch completion only for the branch it holds.
  a_br_done_in_wait: assert property (@(posedge clk) disable iff (rst)
                                      br_done |-> (state_reg == IS_BR_WAIT));

endmodule

// File: tb/tb_mr_issue_ctl.sv
// Bench for mr_issue_ctl: directed table of corner cases, then random traffic
// checked against a counter/flag model of the issue rules.
module tb_mr_issue_ctl;

  typedef struct {
    logic       rst, v;
    logic [4:0] rs1; logic u1;
    logic [4:0] rs2; logic u2;
    logic [4:0] rd;
    logic       br, ar, bd, bt, wv;
    logic [4:0] wr;
    logic       e_av, e_dr, e_fl, e_bz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid, dec_ready, dec_rs1_used, dec_rs2_used, dec_is_br;
  logic [4:0] dec_rs1, dec_rs2, dec_rd, wb_reg;
  logic alu_valid, alu_ready, br_done, br_taken, wb_valid, flush, busy;

  int checks = 0;
  int errors = 0;

  // Reference model: pending writes per register plus branch/flush flags.
  int m_cnt [32];
  bit m_wait, m_flush;

  always #5 clk = ~clk;

  mr_issue_ctl dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs1_used(dec_rs1_used),
    .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_is_br(dec_is_br),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .br_done(br_done), .br_taken(br_taken),
    .wb_valid(wb_valid), .wb_reg(wb_reg),
    .flush(flush), .busy(busy)
  );

  function automatic vec_t mk(input int r, v, rs1, u1, rs2, u2, rd, br, ar, bd, bt, wv, wr,
                              input int av, dr, fl, bz);
    vec_t t;
    t.rst = r[0]; t.v = v[0]; t.rs1 = rs1[4:0]; t.u1 = u1[0]; t.rs2 = rs2[4:0]; t.u2 = u2[0];
    t.rd = rd[4:0]; t.br = br[0]; t.ar = ar[0]; t.bd = bd[0]; t.bt = bt[0]; t.wv = wv[0];
    t.wr = wr[4:0]; t.e_av = av[0]; t.e_dr = dr[0]; t.e_fl = fl[0]; t.e_bz = bz[0];
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d actual=%b required=%b", name, idx, act, exp);
    end
  endtask

  function automatic bit model_hazard(input vec_t t);
    return (t.u1 && t.rs1 != 0 && m_cnt[t.rs1] != 0) ||
           (t.u2 && t.rs2 != 0 && m_cnt[t.rs2] != 0) ||
           (t.rd != 0 && m_cnt[t.rd] == 3);
  endfunction

  // Drive one cycle, compare outputs mid-cycle, then advance the model at the edge.
  task automatic run_vec(input vec_t t, input bit from_tbl, input int idx);
    bit hz, m_av, m_dr, m_fl, m_bz, iss;
    rst = t.rst; dec_valid = t.v; dec_rs1 = t.rs1; dec_rs1_used = t.u1;
    dec_rs2 = t.rs2; dec_rs2_used = t.u2; dec_rd = t.rd; dec_is_br = t.br;
    alu_ready = t.ar; br_done = t.bd; br_taken = t.bt; wb_valid = t.wv; wb_reg = t.wr;
    #2;
    hz = model_hazard(t);
    m_av = 0; m_dr = 0; m_fl = 0;
    if (m_flush) begin m_dr = 1; m_fl = 1; end
    else if (!m_wait) begin m_av = t.v && !hz; m_dr = m_av && t.ar; end
    m_bz = m_wait || m_flush;
    for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) m_bz = 1;
    if (from_tbl) begin
      m_av = t.e_av; m_dr = t.e_dr; m_fl = t.e_fl; m_bz = t.e_bz;
    end
    $display("vec %0d rst=%0b v=%0b rd=%0d br=%0b bd=%0b wb=%0b/%0d -> av=%0b dr=%0b fl=%0b bz=%0b",
             idx, t.rst, t.v, t.rd, t.br, t.bd, t.wv, t.wr, alu_valid, dec_ready, flush, busy);
    chk("alu_valid", idx, alu_valid, m_av);
    chk("dec_ready", idx, dec_ready, m_dr);
    chk("flush", idx, flush, m_fl);
    chk("busy", idx, busy, m_bz);
    iss = !m_wait && !m_flush && t.v && t.ar && !hz;
    @(posedge clk);
    if (t.rst) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_wait = 0; m_flush = 0;
    end else begin
      if (iss && t.rd != 0) m_cnt[t.rd]++;
      if (t.wv && t.wr != 0 && m_cnt[t.wr] > 0) m_cnt[t.wr]--;
      if (m_flush) m_flush = 0;
      else if (m_wait) begin
        if (t.bd) begin m_wait = 0; m_flush = t.bt; end
      end else if (iss && t.br) m_wait = 1;
    end
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t t;
    // rst,v,rs1,u1,rs2,u2,rd,br,ar,bd,bt,wv,wr, av,dr,fl,bz
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));  // reset state
    // RAW stall on x5, released after retire
    tbl.push_back(mk(0,1,0,0,0,0,5,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,1,5,1,0,0,6,0,1,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,5,1,0,0,6,0,1,0,0,1,5, 0,0,0,1));
    tbl.push_back(mk(0,1,5,1,0,0,6,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,6, 0,0,0,1));
    // x0 traffic issues every cycle; alu_ready low holds
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,1,0,1,0,1,0,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0));
    // WAW saturation on x7 and same-cycle inc/dec
    tbl.push_back(mk(0,1,0,0,0,0,7,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,7,0,1,0,0,0,0, 1,1,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,7,0,1,0,0,0,0, 1,1,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,7,0,1,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,7,0,1,0,0,1,7, 0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,7,0,1,0,0,1,7, 1,1,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,7,0,1,0,0,0,0, 1,1,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,7,0,1,0,0,0,0, 0,0,0,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,7, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    // taken branch -> one flush cycle, held op discarded
    tbl.push_back(mk(0,1,0,0,0,0,0,1,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,1,1,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,0,0,0, 0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    // not-taken branch -> next op issues right after br_done
    tbl.push_back(mk(0,1,0,0,0,0,0,1,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,1,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0,0,0,0, 1,1,0,0));
    // JAL with link x1, link retires during BR_WAIT
    tbl.push_back(mk(0,1,0,0,0,0,1,1,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,1,1,1, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    // reset in BR_WAIT with cnt[3]=2
    tbl.push_back(mk(0,1,0,0,0,0,3,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,3,1,1,0,0,0,0, 1,1,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,3,1,0,0,0,0,1,0,0,0,0, 1,1,0,0));
    // reset during FLUSH
    tbl.push_back(mk(0,1,0,0,0,0,0,1,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,1,1,0,0, 0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0,0, 0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    // rs2 RAW; unused sources never stall
    tbl.push_back(mk(0,1,0,0,0,0,9,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,1,9,0,9,1,0,0,1,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,1,9,0,2,0,0,0,1,0,0,0,0, 1,1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,9, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));

    rst = 1; dec_valid = 0; dec_rs1 = 0; dec_rs1_used = 0; dec_rs2 = 0; dec_rs2_used = 0;
    dec_rd = 0; dec_is_br = 0; alu_ready = 0; br_done = 0; br_taken = 0;
    wb_valid = 0; wb_reg = 0;
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_wait = 0; m_flush = 0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) run_vec(tbl[i], 1'b1, i);

    // Random traffic on x0..x7 keeps hazards frequent; protocol respected.
    for (int n = 0; n < 2000; n++) begin
      int r;
      t = mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0);
      t.rst = ($urandom_range(0, 99) == 0);
      t.v   = ($urandom_range(0, 3) != 0);
      t.rs1 = 5'($urandom_range(0, 7)); t.u1 = 1'($urandom_range(0, 1));
      t.rs2 = 5'($urandom_range(0, 7)); t.u2 = 1'($urandom_range(0, 1));
      t.rd  = 5'($urandom_range(0, 7));
      t.br  = ($urandom_range(0, 5) == 0);
      t.ar  = ($urandom_range(0, 3) != 0);
      if (m_wait && $urandom_range(0, 2) == 0) begin
        t.bd = 1; t.bt = 1'($urandom_range(0, 1));
      end
      r = $urandom_range(1, 7);
      if (m_cnt[r] != 0 && $urandom_range(0, 1) == 1) begin
        t.wv = 1; t.wr = 5'(r);
      end else if ($urandom_range(0, 15) == 0) begin
        t.wv = 1; t.wr = 0;
      end
      run_vec(t, 1'b0, tbl.size() + n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
